// File: rtl/load_seq_pkg.sv
// rtl/load_seq_pkg.sv - shared types and beat-count helper for the load sequencer
package load_seq_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    FINISH = 2'b10,
    ERROR  = 2'b11
  } state_e;

  function automatic logic [2:0] beat_count(size_e size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/load_sequencer_width_extender.sv
// rtl/load_sequencer_width_extender.sv - sign/zero extension of an assembled load value
module width_extender
  import load_seq_pkg::*;
(
  input  logic [31:0] data_in,
  input  size_e       size,
  input  logic        sign_en,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (size)
      SZ_BYTE: data_out = {{24{sign_en & data_in[7]}}, data_in[7:0]};
      SZ_HALF: data_out = {{16{sign_en & data_in[15]}}, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_sequencer.sv
// rtl/load_sequencer.sv - byte-serial load controller; LOAD_SEQ_ALIGN_CHECK_EN rejects misaligned half/word loads
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  size_e             size_q;
  logic              signed_q;
  logic [1:0]        cnt_q;
  logic [31:0]       data_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ext_val;
  logic              req_ok;
  logic              last_beat;

  width_extender u_ext (
    .data_in  (data_q),
    .size     (size_q),
    .sign_en  (signed_q),
    .data_out (ext_val)
  );

  always_comb begin
    req_ok = (req_size != SZ_RSVD);
`ifdef LOAD_SEQ_ALIGN_CHECK_EN
    if (req_size == SZ_HALF && req_addr[0]) req_ok = 1'b0;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_ok = 1'b0;
`endif
  end

  assign last_beat = ({1'b0, cnt_q} == (beat_count(size_q) - 3'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = req_ok ? FETCH : ERROR;
      FETCH:   if (mem_ack && last_beat) state_d = FINISH;
      FINISH:  state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result is live in the done cycle and held in rdata_q afterwards.
  always_comb begin
    busy     = (state_q != IDLE);
    mem_req  = (state_q == FETCH);
    done     = (state_q == FINISH) || (state_q == ERROR);
    err      = (state_q == ERROR);
    mem_addr = base_q + ADDR_W'(cnt_q);
    rdata    = rdata_q;
    if (state_q == FINISH) rdata = ext_val;
    else if (state_q == ERROR) rdata = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      cnt_q    <= 2'd0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req && req_ok) begin
            base_q   <= req_addr;
            size_q   <= size_e'(req_size);
            signed_q <= req_signed;
            cnt_q    <= 2'd0;
            data_q   <= '0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            data_q[{cnt_q, 3'b000} +: 8] <= mem_rdata;
            cnt_q                        <= cnt_q + 2'd1;
          end
        end
        FINISH:  rdata_q <= ext_val;
        ERROR:   rdata_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// tb/tb_load_sequencer.sv - scoreboard bench for load_sequencer with a memory responder model
module tb_load_sequencer;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              busy, done, err, mem_req, mem_ack;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  load_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_q[$];
  logic [7:0]  mem_img[logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  bit          stall_rand = 1'b0;
  bit          stall_en = 1'b0;
  logic [31:0] stall_at = '0;
  int          stall_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] t;
    if (mem_img.exists(a)) return mem_img[a];
    t = a * 32'd37 + 32'd5;
    return t[7:0] ^ t[15:8];
  endfunction

  // Reference: gather N little-endian bytes, then extend arithmetically.
  function automatic exp_t model(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    exp_t   e;
    longint v;
    int     n;
    e.err = 1'b0;
    e.rdata = '0;
    v = 0;
    if (sz == 2'b11) begin e.err = 1'b1; return e; end
`ifdef LOAD_SEQ_ALIGN_CHECK_EN
    if ((sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)) begin
      e.err = 1'b1;
      return e;
    end
`endif
    n = 1 << sz;
    for (int i = 0; i < n; i++) v += longint'(mem_byte(a + 32'(i))) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n)) + (longint'(1) << 32);
    e.rdata = v[31:0];
    return e;
  endfunction

  function automatic int stall_for(input logic [31:0] a);
    if (stall_rand) return int'($urandom_range(0, 2));
    if (stall_en && a == stall_at) return stall_n;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                       input bit pulse, output int lat, output int mreq, output logic [31:0] rd);
    exp_t e;
    int   guard;
    e = model(a, sz, sg);
    guard = 0;
    while ((busy || done) && guard < 200) begin tick(); guard++; end
    req_addr = a; req_size = sz; req_signed = sg; req = 1'b1;
    sb_q.push_back(e);
    if (!e.err) for (int i = 0; i < (1 << sz); i++) addr_q.push_back(a + 32'(i));
    tick();
    req = 1'b0;
    lat = 1;
    mreq = 0;
    while (!done && lat < 200) begin
      if (mem_req) mreq++;
      req = (pulse && lat == 2);
      if (req) begin req_size = 2'b00; req_addr = a + 32'h40; end
      tick();
      lat++;
    end
    req = 1'b0;
    chk("done_timeout", {63'd0, done}, 64'd1);
    rd = rdata;
    tick();
    chk("rdata_hold", {32'd0, rdata}, {32'd0, e.rdata});
  endtask

  // Memory responder: per-beat stall, then ack with the modelled byte.
  initial begin
    int w;
    w = -1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (w < 0) w = stall_for(mem_addr);
        if (w == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_byte(mem_addr);
          w = -1;
          chk("beat_expected", {63'd0, addr_q.size() > 0}, 64'd1);
          if (addr_q.size() > 0) chk("mem_addr", {32'd0, mem_addr}, {32'd0, addr_q.pop_front()});
        end else begin
          w--;
        end
      end else begin
        w = -1;
        if (stall_rand && $urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  // Monitor: every done pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (err && !done) chk("err_needs_done", {63'd0, done}, 64'd1);
      if (done) begin
        n_done++;
        chk("done_expected", {63'd0, sb_q.size() > 0}, 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("err", {63'd0, err}, {63'd0, e.err});
          chk("rdata", {32'd0, rdata}, {32'd0, e.rdata});
        end
      end
    end
  end

  initial begin
    int          lat, mr, d0;
    logic [31:0] rd, a;
    rst = 1'b1; req = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ctrl", {60'd0, busy, done, err, mem_req}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_addr", {32'd0, mem_addr}, 64'd0);

    mem_img[32'h10] = 8'h80;
    issue(32'h10, 2'b00, 1'b1, 1'b0, lat, mr, rd);
    chk("sbyte_lat", 64'(lat), 64'd2);
    chk("sbyte_val", {32'd0, rd}, 64'hFFFF_FF80);

    mem_img[32'h100] = 8'h34;
    mem_img[32'h101] = 8'h82;
    issue(32'h100, 2'b01, 1'b0, 1'b0, lat, mr, rd);
    chk("uhalf_lat", 64'(lat), 64'd3);
    chk("uhalf_val", {32'd0, rd}, 64'h0000_8234);
    issue(32'h100, 2'b01, 1'b1, 1'b0, lat, mr, rd);
    chk("shalf_val", {32'd0, rd}, 64'hFFFF_8234);

    mem_img[32'h200] = 8'h78; mem_img[32'h201] = 8'h56;
    mem_img[32'h202] = 8'h34; mem_img[32'h203] = 8'h12;
    stall_en = 1'b1; stall_at = 32'h201; stall_n = 2;
    issue(32'h200, 2'b10, 1'b1, 1'b0, lat, mr, rd);
    stall_en = 1'b0;
    chk("word_stall_lat", 64'(lat), 64'd7);
    chk("word_stall_mreq", 64'(mr), 64'd6);
    chk("word_val", {32'd0, rd}, 64'h1234_5678);

    issue(32'h101, 2'b01, 1'b1, 1'b0, lat, mr, rd);
`ifdef LOAD_SEQ_ALIGN_CHECK_EN
    chk("mis_half_lat", 64'(lat), 64'd1);
    chk("mis_half_mreq", 64'(mr), 64'd0);
`else
    chk("mis_half_lat", 64'(lat), 64'd3);
    chk("mis_half_mreq", 64'(mr), 64'd2);
`endif

    issue(32'h40, 2'b11, 1'b0, 1'b0, lat, mr, rd);
    chk("rsvd_lat", 64'(lat), 64'd1);
    chk("rsvd_mreq", 64'(mr), 64'd0);

    d0 = n_done;
    issue(32'h400, 2'b10, 1'b0, 1'b1, lat, mr, rd);
    repeat (4) tick();
    chk("single_done", 64'(n_done - d0), 64'd1);
    chk("pulse_word_lat", 64'(lat), 64'd5);

    // Abort a word load after its second beat.
    d0 = n_done;
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h300 + 32'(i));
    req_addr = 32'h300; req_size = 2'b10; req_signed = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ctrl", {60'd0, busy, done, err, mem_req}, 64'd0);
    chk("abort_rdata", {32'd0, rdata}, 64'd0);
    chk("abort_addr", {32'd0, mem_addr}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    addr_q.delete();
    repeat (2) tick();
    chk("abort_no_done", 64'(n_done - d0), 64'd0);
    issue(32'h10, 2'b00, 1'b0, 1'b0, lat, mr, rd);
    chk("post_rst_lat", 64'(lat), 64'd2);
    chk("post_rst_val", {32'd0, rd}, 64'h0000_0080);

    stall_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
      issue(a, 2'($urandom_range(0, 3)), 1'($urandom), 1'b0, lat, mr, rd);
    end
    stall_rand = 1'b0;

    repeat (5) tick();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    chk("addr_drain", 64'(addr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
